radix2_butterfly_pipe: RTL and testbench

RADIX2_BUTTERFLY_PIPE -- requirements
Module: radix2_butterfly_pipe

---
 rtl/radix2_butterfly_pipe_if.sv | 35 +++
 rtl/radix2_butterfly_pipe.sv | 166 ++++++++++++++++
 tb/tb_radix2_butterfly_pipe.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/radix2_butterfly_pipe_if.sv
// Streaming port bundle for the radix-2 butterfly: operand/twiddle input side and result output side.
// A transfer happens on a rising clk edge where valid and ready are both high; once valid is
// raised the sender holds payload and valid stable until that edge, and ready may depend on valid.
interface radix2_butterfly_pipe_if #(
  parameter int DW = 16,
  parameter int TW = 16
);
  logic signed [DW-1:0] x1_r;
  logic signed [DW-1:0] x1_i;
  logic signed [DW-1:0] x2_r;
  logic signed [DW-1:0] x2_i;
  logic signed [TW-1:0] w_r;
  logic signed [TW-1:0] w_i;
  logic                 dif_mode;
  logic                 scale;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] y1_r;
  logic signed [DW-1:0] y1_i;
  logic signed [DW-1:0] y2_r;
  logic signed [DW-1:0] y2_i;
  logic                 out_valid;
  logic                 out_ready;
  logic                 sat_flag;

  modport master (
    output x1_r, x1_i, x2_r, x2_i, w_r, w_i, dif_mode, scale, in_valid, out_ready,
    input  in_ready, y1_r, y1_i, y2_r, y2_i, out_valid, sat_flag
  );

  modport slave (
    input  x1_r, x1_i, x2_r, x2_i, w_r, w_i, dif_mode, scale, in_valid, out_ready,
    output in_ready, y1_r, y1_i, y2_r, y2_i, out_valid, sat_flag
  );
endinterface

// File: rtl/radix2_butterfly_pipe.sv
// Three-stage radix-2 butterfly (DIF or DIT per sample) with optional divide-by-2, round half up
// and output saturation. One global enable stalls the whole pipeline under output backpressure.
module radix2_butterfly_pipe #(
  parameter int DW = 16,
  parameter int TW = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  radix2_butterfly_pipe_if.slave bus
);
  localparam int PW = DW + TW;
  localparam int CW = DW + TW + 2;
  localparam logic signed [CW-1:0] ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic signed [CW-1:0] DW_MAX = {{(CW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [CW-1:0] DW_MIN = {{(CW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [CW-1:0] T_MAX  = {{(CW-DW){1'b0}}, {DW{1'b1}}};
  localparam logic signed [CW-1:0] T_MIN  = {{(CW-DW){1'b1}}, {DW{1'b0}}};

  // Returns {overflow, clamped DW-bit value}.
  function automatic logic [DW:0] sat_dw(input logic signed [CW-1:0] v);
    if (v > DW_MAX)      sat_dw = {1'b1, DW_MAX[DW-1:0]};
    else if (v < DW_MIN) sat_dw = {1'b1, DW_MIN[DW-1:0]};
    else                 sat_dw = {1'b0, v[DW-1:0]};
  endfunction

  function automatic logic signed [CW-1:0] sat_t(input logic signed [CW-1:0] v);
    if (v > T_MAX)      sat_t = T_MAX;
    else if (v < T_MIN) sat_t = T_MIN;
    else                sat_t = v;
  endfunction

  logic ce;
  assign ce          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = ce;

  // S1: multiplier operand a (x1-x2 for DIF, x2 for DIT) and pass-through p (x1+x2 for DIF, x1 for DIT)
  logic                 v1_q, dif1_q, sc1_q;
  logic signed [DW:0]   a1_q [2];
  logic signed [DW:0]   p1_q [2];
  logic signed [TW-1:0] w1_q [2];
  logic signed [DW:0]   a1_d [2];
  logic signed [DW:0]   p1_d [2];

  always_comb begin
    if (bus.dif_mode) begin
      a1_d[0] = (DW+1)'(bus.x1_r) - (DW+1)'(bus.x2_r);
      a1_d[1] = (DW+1)'(bus.x1_i) - (DW+1)'(bus.x2_i);
      p1_d[0] = (DW+1)'(bus.x1_r) + (DW+1)'(bus.x2_r);
      p1_d[1] = (DW+1)'(bus.x1_i) + (DW+1)'(bus.x2_i);
    end else begin
      a1_d[0] = (DW+1)'(bus.x2_r);
      a1_d[1] = (DW+1)'(bus.x2_i);
      p1_d[0] = (DW+1)'(bus.x1_r);
      p1_d[1] = (DW+1)'(bus.x1_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      dif1_q <= 1'b0;
      sc1_q  <= 1'b0;
      a1_q   <= '{default: '0};
      p1_q   <= '{default: '0};
      w1_q   <= '{default: '0};
    end else if (ce) begin
      v1_q    <= bus.in_valid;
      dif1_q  <= bus.dif_mode;
      sc1_q   <= bus.scale;
      a1_q    <= a1_d;
      p1_q    <= p1_d;
      w1_q[0] <= bus.w_r;
      w1_q[1] <= bus.w_i;
    end
  end

  // S2: four partial products, each provably within PW bits
  logic                 v2_q, dif2_q, sc2_q;
  logic signed [DW:0]   p2_q [2];
  logic signed [PW-1:0] rr_q, ii_q, ri_q, ir_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q   <= 1'b0;
      dif2_q <= 1'b0;
      sc2_q  <= 1'b0;
      p2_q   <= '{default: '0};
      rr_q   <= '0;
      ii_q   <= '0;
      ri_q   <= '0;
      ir_q   <= '0;
    end else if (ce) begin
      v2_q   <= v1_q;
      dif2_q <= dif1_q;
      sc2_q  <= sc1_q;
      p2_q   <= p1_q;
      rr_q   <= PW'(a1_q[0]) * PW'(w1_q[0]);
      ii_q   <= PW'(a1_q[1]) * PW'(w1_q[1]);
      ri_q   <= PW'(a1_q[0]) * PW'(w1_q[1]);
      ir_q   <= PW'(a1_q[1]) * PW'(w1_q[0]);
    end
  end

  // S3: DIF folds the scale into the product shift; DIT rounds t at unit gain, then scales the sums
  logic [7:0]           sh;
  logic signed [CW-1:0] rc;
  logic signed [CW-1:0] cplx  [2];
  logic signed [CW-1:0] rnd   [2];
  logic signed [CW-1:0] t     [2];
  logic signed [CW-1:0] pe    [2];
  logic signed [CW-1:0] y1_l  [2];
  logic signed [CW-1:0] y2_l  [2];
  logic signed [CW-1:0] y1_p  [2];
  logic signed [CW-1:0] y2_p  [2];
  logic [DW:0]          y1_s  [2];
  logic [DW:0]          y2_s  [2];
  logic                 sat_d;

  always_comb begin
    sh      = (dif2_q && sc2_q) ? 8'(TW) : 8'(TW - 1);
    rc      = ONE <<< (sh - 8'd1);
    cplx[0] = CW'(rr_q) - CW'(ii_q);
    cplx[1] = CW'(ri_q) + CW'(ir_q);
    for (int k = 0; k < 2; k++) begin
      rnd[k]  = (cplx[k] + rc) >>> sh;
      t[k]    = sat_t(rnd[k]);
      pe[k]   = CW'(p2_q[k]);
      y1_l[k] = dif2_q ? pe[k] : pe[k] + t[k];
      y2_l[k] = pe[k] - t[k];
      y1_p[k] = sc2_q ? (y1_l[k] + ONE) >>> 1 : y1_l[k];
      y2_p[k] = dif2_q ? rnd[k] : (sc2_q ? (y2_l[k] + ONE) >>> 1 : y2_l[k]);
      y1_s[k] = sat_dw(y1_p[k]);
      y2_s[k] = sat_dw(y2_p[k]);
    end
    sat_d = y1_s[0][DW] | y1_s[1][DW] | y2_s[0][DW] | y2_s[1][DW];
  end

  logic                 ov_q, sat_q;
  logic signed [DW-1:0] y1_q [2];
  logic signed [DW-1:0] y2_q [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      ov_q  <= 1'b0;
      sat_q <= 1'b0;
      y1_q  <= '{default: '0};
      y2_q  <= '{default: '0};
    end else if (ce) begin
      ov_q <= v2_q;
      if (v2_q) begin
        sat_q   <= sat_d;
        y1_q[0] <= y1_s[0][DW-1:0];
        y1_q[1] <= y1_s[1][DW-1:0];
        y2_q[0] <= y2_s[0][DW-1:0];
        y2_q[1] <= y2_s[1][DW-1:0];
      end
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.sat_flag  = sat_q;
  assign bus.y1_r      = y1_q[0];
  assign bus.y1_i      = y1_q[1];
  assign bus.y2_r      = y2_q[0];
  assign bus.y2_i      = y2_q[1];
endmodule

// File: tb/tb_radix2_butterfly_pipe.sv
// Bench for radix2_butterfly_pipe: known vectors, mixed-mode stream against a longint model,
// backpressure stall and mid-stream reset.
module tb_radix2_butterfly_pipe;
  localparam int DW = 16;
  localparam int TW = 16;
  localparam int RW = 4 * DW + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  radix2_butterfly_pipe_if #(.DW(DW), .TW(TW)) bus ();
  radix2_butterfly_pipe #(.DW(DW), .TW(TW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic signed [DW-1:0] x1r, x1i, x2r, x2i, wr, wi;
    logic                 dif, sc;
    logic signed [DW-1:0] y1r, y1i, y2r, y2i;
    logic                 sat;
  } vec_t;

  vec_t           tbl [7];
  logic [RW-1:0]  exp_q [$];
  logic [RW-1:0]  last_exp = '0;
  int             checks = 0;
  int             failures = 0;
  int             n_out = 0;

  function automatic vec_t mk(input int x1r, x1i, x2r, x2i, wr, wi, dif, sc,
                              input int y1r, y1i, y2r, y2i, sat);
    vec_t v;
    v.x1r = 16'(x1r); v.x1i = 16'(x1i); v.x2r = 16'(x2r); v.x2i = 16'(x2i);
    v.wr  = 16'(wr);  v.wi  = 16'(wi);  v.dif = 1'(dif);  v.sc  = 1'(sc);
    v.y1r = 16'(y1r); v.y1i = 16'(y1i); v.y2r = 16'(y2r); v.y2i = 16'(y2i);
    v.sat = 1'(sat);
    return v;
  endfunction

  function automatic logic [RW-1:0] pack_exp(input vec_t v);
    return {v.y1r, v.y1i, v.y2r, v.y2i, v.sat};
  endfunction

  function automatic string fmt(input logic [RW-1:0] r);
    return $sformatf("y1=(%0d,%0d) y2=(%0d,%0d) sat=%0b", $signed(r[64:49]), $signed(r[48:33]),
                     $signed(r[32:17]), $signed(r[16:1]), r[0]);
  endfunction

  function automatic longint rnd_sh(input longint v, input int sh);
    return (v + (longint'(1) << (sh - 1))) >>> sh;
  endfunction

  function automatic longint lim(input longint v, input int bits, inout bit f);
    longint hi = (longint'(1) << (bits - 1)) - 1;
    longint lo = -hi - 1;
    if (v > hi) begin f = 1'b1; return hi; end
    if (v < lo) begin f = 1'b1; return lo; end
    return v;
  endfunction

  function automatic logic [RW-1:0] model(input vec_t v);
    longint x1r = longint'(v.x1r);
    longint x1i = longint'(v.x1i);
    longint x2r = longint'(v.x2r);
    longint x2i = longint'(v.x2i);
    longint wr  = longint'(v.wr);
    longint wi  = longint'(v.wi);
    longint ar, ai, pr, pi, tr, ti, y1r, y1i, y2r, y2i;
    bit f = 1'b0;
    bit tf = 1'b0;
    if (v.dif) begin
      y1r = x1r + x2r;
      y1i = x1i + x2i;
      if (v.sc) begin y1r = rnd_sh(y1r, 1); y1i = rnd_sh(y1i, 1); end
      ar  = x1r - x2r;
      ai  = x1i - x2i;
      pr  = ar * wr - ai * wi;
      pi  = ar * wi + ai * wr;
      y2r = rnd_sh(pr, TW - 1 + int'(v.sc));
      y2i = rnd_sh(pi, TW - 1 + int'(v.sc));
    end else begin
      pr  = x2r * wr - x2i * wi;
      pi  = x2r * wi + x2i * wr;
      tr  = lim(rnd_sh(pr, TW - 1), DW + 1, tf);
      ti  = lim(rnd_sh(pi, TW - 1), DW + 1, tf);
      y1r = x1r + tr; y1i = x1i + ti;
      y2r = x1r - tr; y2i = x1i - ti;
      if (v.sc) begin
        y1r = rnd_sh(y1r, 1); y1i = rnd_sh(y1i, 1);
        y2r = rnd_sh(y2r, 1); y2i = rnd_sh(y2i, 1);
      end
    end
    y1r = lim(y1r, DW, f); y1i = lim(y1i, DW, f);
    y2r = lim(y2r, DW, f); y2i = lim(y2i, DW, f);
    return {16'(y1r), 16'(y1i), 16'(y2r), 16'(y2i), f};
  endfunction

  task automatic chk(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] dut_out();
    return {bus.y1_r, bus.y1_i, bus.y2_r, bus.y2_i, bus.sat_flag};
  endfunction

  // scoreboard: pop on each output handshake that the coming edge will complete
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      logic [RW-1:0] got, e;
      got = dut_out();
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_extra_output got %s expected none", fmt(got));
      end else begin
        e = exp_q.pop_front();
        last_exp = e;
        n_out++;
        if (got !== e) begin
          failures++;
          $display("FAIL out_sample_%0d got %s expected %s", n_out, fmt(got), fmt(e));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input vec_t v, input logic [RW-1:0] e);
    int g = 0;
    bus.x1_r = v.x1r; bus.x1_i = v.x1i; bus.x2_r = v.x2r; bus.x2_i = v.x2i;
    bus.w_r = v.wr; bus.w_i = v.wi; bus.dif_mode = v.dif; bus.scale = v.sc;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && g < 100) begin @(negedge clk); g++; end
    if (!bus.in_ready) begin
      checks++; failures++;
      $display("FAIL in_ready_timeout got=0 expected=1");
    end else if (!rst) begin
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int g = 0;
    while (exp_q.size() != 0 && g < 100) begin idle(1); g++; end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_%s pending=%0d expected=0", tag, exp_q.size());
    end
  endtask

  function automatic vec_t rand_vec(input int dif, input int sc);
    return mk(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
              int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
              int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
              dif, sc, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t seq_vec(input int k);
    return mk(k * 100, -k * 50, k, 2 * k, 20000, -10000, k % 2, 0, 0, 0, 0, 0, 0);
  endfunction

  initial begin
    int c0;
    vec_t v;
    tbl[0] = mk(1000, 200, 400, -100, 32767, 0, 1, 0, 1400, 100, 600, 300, 0);
    tbl[1] = mk(100, 0, 0, 50, 0, -32768, 0, 0, 150, 0, 50, 0, 0);
    tbl[2] = mk(32767, 0, 1, 0, 32767, 0, 1, 0, 32767, 0, 32765, 0, 1);
    tbl[3] = mk(32767, 0, 1, 0, 32767, 0, 1, 1, 16384, 0, 16383, 0, 0);
    tbl[4] = mk(-1000, 300, 200, -400, 16384, 16384, 0, 1, -350, 100, -650, 200, 0);
    tbl[5] = mk(-32768, -32768, -32768, 0, 32767, 0, 0, 0, -32768, -32768, -1, -32768, 1);
    tbl[6] = mk(3, -3, 0, 0, 0, 32767, 1, 1, 2, -1, 1, 1, 0);

    bus.x1_r = '0; bus.x1_i = '0; bus.x2_r = '0; bus.x2_i = '0;
    bus.w_r = '0; bus.w_i = '0; bus.dif_mode = 1'b0; bus.scale = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", RW'(bus.out_valid), RW'(0));
    chk("reset_outputs", dut_out(), RW'(0));
    chk("reset_in_ready", RW'(bus.in_ready), RW'(1));
    idle(1);

    // known vectors with random bubbles between them
    for (int i = 0; i < 7; i++) begin
      send(tbl[i], pack_exp(tbl[i]));
      idle(int'($urandom_range(0, 2)));
    end
    drain("table");
    idle(3);
    @(negedge clk);
    chk("bubble_out_valid", RW'(bus.out_valid), RW'(0));
    chk("bubble_outputs_held", dut_out(), last_exp);
    idle(1);

    // mixed mode/scale at full rate
    c0 = cyc;
    for (int i = 0; i < 40; i++) begin
      v = rand_vec(i % 2, (i / 2 + i) % 2);
      send(v, model(v));
    end
    chk("full_throughput_cycles", RW'(cyc - c0), RW'(40));
    drain("mixed");

    // backpressure: stall 4 cycles once the first result is presented
    fork
      begin
        for (int k = 1; k <= 5; k++) begin
          v = seq_vec(k);
          send(v, model(v));
        end
      end
      begin
        idle(4);
        bus.out_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
          @(negedge clk);
          chk($sformatf("stall%0d_in_ready", s), RW'(bus.in_ready), RW'(0));
          chk($sformatf("stall%0d_out_valid", s), RW'(bus.out_valid), RW'(1));
          chk($sformatf("stall%0d_held", s), dut_out(), (exp_q.size() > 0) ? exp_q[0] : RW'(0));
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    drain("backpressure");

    // reset with two samples in flight
    v = seq_vec(7);
    send(v, model(v));
    v = seq_vec(8);
    send(v, model(v));
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_out_valid", RW'(bus.out_valid), RW'(0));
    chk("midrst_outputs", dut_out(), RW'(0));
    chk("midrst_in_ready", RW'(bus.in_ready), RW'(1));
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      chk($sformatf("midrst_no_stale%0d", s), RW'(bus.out_valid), RW'(0));
    end
    idle(1);

    send(tbl[4], pack_exp(tbl[4]));
    drain("after_reset");
    chk("outputs_delivered", RW'(n_out), RW'(7 + 40 + 5 + 1));
    chk("queue_empty", RW'(exp_q.size()), RW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end
endmodule
